// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq
// Purpose  : Program-counter sequencer. Issues sequential instruction fetches,
//            holds on downstream stall, and redirects the PC on jumps with a
//            one-cycle pipeline flush.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            we_jmp, jmp_addr  - jump write enable and 16-bit target
//            stall             - downstream stall (no fetch issued or accepted)
//            fetch_req/addr    - fetch request and address (addr == pc)
//            fetch_ack         - memory accepted the fetch; data next cycle
//            inst_valid        - returned word for the previous acked fetch
//            flush             - discard any in-flight instruction
//            pc                - current program counter
//            call, ret         - return-stack push / pop (optional)
// Options  : define PC_SEQ_CALL_STACK_EN to build a 4-entry x 16-bit circular
//            return-address stack together with the call and ret ports.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_jmp,
    input  logic [15:0] jmp_addr,
    input  logic        stall,
    output logic        fetch_req,
    output logic [15:0] fetch_addr,
    input  logic        fetch_ack,
    output logic        inst_valid,
    output logic        flush,
`ifdef PC_SEQ_CALL_STACK_EN
    input  logic        call,
    input  logic        ret,
`endif
    output logic [15:0] pc
);

    localparam logic [1:0] c_ST_RST   = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic        r_inst_valid;
    logic        w_inst_valid_nxt;

`ifdef PC_SEQ_CALL_STACK_EN
    localparam logic [2:0] c_STACK_FULL = 3'd4;

    // Circular buffer: r_wp is the next slot to write, so the top entry sits
    // at r_wp-1. When full, a push lands on the oldest entry automatically.
    logic [15:0] r_stack [0:3];
    logic [1:0]  r_wp;
    logic [2:0]  r_depth;
    logic [1:0]  w_top_idx;
    logic        w_push;
    logic        w_pop;

    assign w_top_idx = r_wp - 2'd1;
`endif

    // ------------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_RST;
            r_pc         <= 16'h0000;
            r_inst_valid <= 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
            r_wp         <= 2'd0;
            r_depth      <= 3'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
`ifdef PC_SEQ_CALL_STACK_EN
            if (w_push) begin
                r_wp <= r_wp + 2'd1;
                if (r_depth != c_STACK_FULL) begin
                    r_depth <= r_depth + 3'd1;
                end
            end else if (w_pop) begin
                r_wp    <= w_top_idx;
                r_depth <= r_depth - 3'd1;
            end
`endif
        end
    end

`ifdef PC_SEQ_CALL_STACK_EN
    // Stack storage needs no reset: the depth counter gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_wp] <= r_pc + 16'd1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state / next-PC logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_valid_nxt = 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
        w_push           = 1'b0;
        w_pop            = 1'b0;
`endif

        case (r_state)
            c_ST_RST: begin
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (stall) begin
                    w_state_nxt = c_ST_HOLD;
                end else if (fetch_ack) begin
                    w_pc_nxt         = r_pc + 16'd1;
                    w_inst_valid_nxt = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (!stall) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FLUSH: begin
                w_state_nxt = stall ? c_ST_HOLD : c_ST_FETCH;
            end
            default: begin
                w_state_nxt = c_ST_RST;
            end
        endcase

        // Redirects apply in every state except RST and override both the
        // increment and the stall path; any word acked this cycle is dropped.
        if (r_state != c_ST_RST) begin
            if (we_jmp) begin
                w_pc_nxt         = jmp_addr;
                w_inst_valid_nxt = 1'b0;
                w_state_nxt      = c_ST_FLUSH;
`ifdef PC_SEQ_CALL_STACK_EN
                // A simultaneous ret is ignored; only call alters the stack.
                w_push           = call;
            end else if (ret) begin
                w_pc_nxt         = (r_depth != 3'd0) ? r_stack[w_top_idx] : 16'h0000;
                w_pop            = (r_depth != 3'd0);
                w_inst_valid_nxt = 1'b0;
                w_state_nxt      = c_ST_FLUSH;
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        fetch_req  = (r_state == c_ST_FETCH) && !stall;
        flush      = (r_state == c_ST_FLUSH);
        inst_valid = r_inst_valid;
        pc         = r_pc;
        fetch_addr = r_pc;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_seq
// Purpose  : Directed self-checking bench for pc_seq. Stack scenarios are
//            built only when PC_SEQ_CALL_STACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        we_jmp;
    logic [15:0] jmp_addr;
    logic        stall;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic        inst_valid;
    logic        flush;
    logic [15:0] pc;
    logic        call;
    logic        ret;

    int checks   = 0;
    int failures = 0;

    pc_seq dut (
        .clk        (clk),
        .rst        (rst),
        .we_jmp     (we_jmp),
        .jmp_addr   (jmp_addr),
        .stall      (stall),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .inst_valid (inst_valid),
        .flush      (flush),
`ifdef PC_SEQ_CALL_STACK_EN
        .call       (call),
        .ret        (ret),
`endif
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Redirect to addr with a plain jump and settle in FETCH at addr.
    task automatic goto(input logic [15:0] addr);
        we_jmp = 1'b1; jmp_addr = addr; fetch_ack = 1'b0; stall = 1'b0;
        tick();
        we_jmp = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; we_jmp = 1'b1; jmp_addr = 16'h1234; fetch_ack = 1'b1; stall = 1'b0;
        call = 1'b0; ret = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL reset_fetch_req got=%b exp=0", fetch_req); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_addr [0:2];
        logic        exp_vld  [0:2];
        exp_addr[0] = 16'h0000; exp_addr[1] = 16'h0001; exp_addr[2] = 16'h0002;
        exp_vld[0]  = 1'b0;     exp_vld[1]  = 1'b1;     exp_vld[2]  = 1'b1;
        rst = 1'b0; we_jmp = 1'b0; fetch_ack = 1'b1; stall = 1'b0;
        #1;
        // First cycle after release is RST: no fetch yet.
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL seq_rst_req got=%b exp=0", fetch_req); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (fetch_req !== 1'b1 || fetch_addr !== exp_addr[i])
                begin failures++; $display("FAIL seq_fetch%0d got req=%b addr=%h exp req=1 addr=%h", i, fetch_req, fetch_addr, exp_addr[i]); end
            checks++; if (inst_valid !== exp_vld[i])
                begin failures++; $display("FAIL seq_valid%0d got=%b exp=%b", i, inst_valid, exp_vld[i]); end
            tick();
        end
    endtask

    task automatic test_jump();
        goto(16'h0010);
        checks++; if (fetch_req !== 1'b1 || pc !== 16'h0010) begin failures++; $display("FAIL jmp_setup got req=%b pc=%h exp req=1 pc=0010", fetch_req, pc); end
        we_jmp = 1'b1; jmp_addr = 16'h0200; fetch_ack = 1'b1;
        tick();
        checks++; if (flush !== 1'b1 || inst_valid !== 1'b0 || pc !== 16'h0200 || fetch_req !== 1'b0)
            begin failures++; $display("FAIL jmp_flush got flush=%b vld=%b pc=%h req=%b exp 1 0 0200 0", flush, inst_valid, pc, fetch_req); end
        we_jmp = 1'b0;
        tick();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0200 || flush !== 1'b0 || inst_valid !== 1'b0)
            begin failures++; $display("FAIL jmp_refetch got req=%b addr=%h flush=%b vld=%b exp 1 0200 0 0", fetch_req, fetch_addr, flush, inst_valid); end
    endtask

    task automatic test_wrap();
        goto(16'hFFFF);
        fetch_ack = 1'b1;
        tick();
        checks++; if (pc !== 16'h0000 || inst_valid !== 1'b1)
            begin failures++; $display("FAIL wrap got pc=%h vld=%b exp pc=0000 vld=1", pc, inst_valid); end
        fetch_ack = 1'b0;
    endtask

    task automatic test_stall();
        goto(16'h0040);
        stall = 1'b1; fetch_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (fetch_req !== 1'b0 || pc !== 16'h0040)
                begin failures++; $display("FAIL stall%0d got req=%b pc=%h exp req=0 pc=0040", i, fetch_req, pc); end
            tick();
        end
        // HOLD with stall released: still no request, and an ack is ignored.
        stall = 1'b0;
        #1;
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL hold_exit_req got=%b exp=0", fetch_req); end
        tick();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0040 || inst_valid !== 1'b0)
            begin failures++; $display("FAIL stall_resume got req=%b addr=%h vld=%b exp 1 0040 0", fetch_req, fetch_addr, inst_valid); end
        tick();
        checks++; if (pc !== 16'h0041 || inst_valid !== 1'b1)
            begin failures++; $display("FAIL stall_after got pc=%h vld=%b exp 0041 1", pc, inst_valid); end
        fetch_ack = 1'b0;
    endtask

    task automatic test_jump_in_flush();
        we_jmp = 1'b1; jmp_addr = 16'h0300;
        tick();
        jmp_addr = 16'h0400;
        tick();
        checks++; if (flush !== 1'b1 || pc !== 16'h0400)
            begin failures++; $display("FAIL flush_ext got flush=%b pc=%h exp 1 0400", flush, pc); end
        we_jmp = 1'b0;
        tick();
        checks++; if (flush !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 16'h0400)
            begin failures++; $display("FAIL flush_ext_end got flush=%b req=%b addr=%h exp 0 1 0400", flush, fetch_req, fetch_addr); end
    endtask

    task automatic test_jump_stall();
        stall = 1'b1; we_jmp = 1'b1; jmp_addr = 16'h0500;
        tick();
        checks++; if (flush !== 1'b1 || pc !== 16'h0500)
            begin failures++; $display("FAIL jmp_stall got flush=%b pc=%h exp 1 0500", flush, pc); end
        we_jmp = 1'b0;
        tick();
        checks++; if (flush !== 1'b0 || fetch_req !== 1'b0 || pc !== 16'h0500)
            begin failures++; $display("FAIL jmp_stall_hold got flush=%b req=%b pc=%h exp 0 0 0500", flush, fetch_req, pc); end
        stall = 1'b0;
        tick();
        checks++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0500)
            begin failures++; $display("FAIL jmp_stall_resume got req=%b addr=%h exp 1 0500", fetch_req, fetch_addr); end
    endtask

    task automatic test_rst_mid_fetch();
        fetch_ack = 1'b1; rst = 1'b1;
        tick();
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rstmid_pc got=%h exp=0000", pc); end
        rst = 1'b0;
        #1;
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", fetch_req); end
        tick();
        checks++; if (pc !== 16'h0000 || inst_valid !== 1'b0)
            begin failures++; $display("FAIL rstmid_ack_ignored got pc=%h vld=%b exp 0000 0", pc, inst_valid); end
        fetch_ack = 1'b0;
    endtask

`ifdef PC_SEQ_CALL_STACK_EN
    task automatic test_call_ret();
        goto(16'h0020);
        call = 1'b1; we_jmp = 1'b1; jmp_addr = 16'h0100;
        tick();
        checks++; if (pc !== 16'h0100) begin failures++; $display("FAIL call_pc got=%h exp=0100", pc); end
        call = 1'b0; we_jmp = 1'b0;
        tick();
        ret = 1'b1;
        tick();
        checks++; if (pc !== 16'h0021 || flush !== 1'b1)
            begin failures++; $display("FAIL ret_pc got pc=%h flush=%b exp 0021 1", pc, flush); end
        ret = 1'b0;
        tick();
    endtask

    task automatic test_stack_overflow();
        logic [15:0] exp_ret [0:4];
        exp_ret[0] = 16'h1004; exp_ret[1] = 16'h1003; exp_ret[2] = 16'h1002;
        exp_ret[3] = 16'h1001; exp_ret[4] = 16'h0000;
        // pc is 0x0021; five nested calls push 0x0022 (later overwritten),
        // 0x1001, 0x1002, 0x1003, 0x1004.
        call = 1'b1; we_jmp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jmp_addr = 16'h1000 + 16'(i);
            tick();
        end
        call = 1'b0; we_jmp = 1'b0; ret = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (pc !== exp_ret[i] || flush !== 1'b1)
                begin failures++; $display("FAIL ovf_ret%0d got pc=%h flush=%b exp %h 1", i, pc, flush, exp_ret[i]); end
        end
        ret = 1'b0;
        tick();
    endtask

    task automatic test_ret_with_jump();
        goto(16'h0000);
        call = 1'b1; we_jmp = 1'b1; jmp_addr = 16'h2000;
        tick();
        call = 1'b0; ret = 1'b1; jmp_addr = 16'h3000;
        tick();
        checks++; if (pc !== 16'h3000) begin failures++; $display("FAIL retjmp_pc got=%h exp=3000", pc); end
        we_jmp = 1'b0;
        tick();
        checks++; if (pc !== 16'h0001) begin failures++; $display("FAIL retjmp_stack got=%h exp=0001", pc); end
        ret = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_wrap();
        test_stall();
        test_jump_in_flush();
        test_jump_stall();
        test_rst_mid_fetch();
`ifdef PC_SEQ_CALL_STACK_EN
        test_call_ret();
        test_stack_overflow();
        test_ret_with_jump();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
